// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive framer.
// Latency: n/a (types only). Backpressure: n/a.
// PID nibbles are the low nibble of the PID byte; the high nibble carries their complement.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_RX,
        PID_RX,
        DATA_RX,
        ERR
    } rx_state_t;

    localparam logic [7:0] SYNC_VAL  = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/rx_byte_shifter.sv
// LSB-first byte assembler: shift register, 3-bit bit counter, byte_done strobe.
// Latency: byte_done/byte_dat are combinational in the cycle of the 8th strobe.
// Backpressure: none; every shift_enable is consumed.
module rx_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_enable,
    input  logic       d_orig,
    output logic [2:0] bit_cnt,
    output logic       byte_done,
    output logic [7:0] byte_dat
);

    logic [7:0] sr;

    // Completed byte includes the bit arriving on this strobe.
    assign byte_dat  = {d_orig, sr[7:1]};
    assign byte_done = shift_enable && !clr && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (clr) begin
            bit_cnt <= 3'd0;
        end else if (shift_enable) begin
            sr      <= byte_dat;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/usb_rx_pid_framer.sv
// USB RX framer: SYNC detect, PID capture/check, data byte streaming, EOP framing.
// Latency: all outputs registered, one cycle after the triggering strobe.
// Backpressure: none; optional idle-strobe timeout under RX_TIMEOUT_EN.
module usb_rx_pid_framer
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_VAL,
    parameter int         MAX_BYTES   = 1027,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           d_orig,
    input  logic                           shift_enable,
    input  logic                           eop,
    output logic [7:0]                     PID_I,
    output logic                           EOP_flag,
    output logic [7:0]                     rcv_data,
    output logic                           byte_received,
    output logic [$clog2(MAX_BYTES+1)-1:0] byte_cnt,
    output logic                           rcving,
    output logic                           pid_err,
    output logic                           rx_error
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    rx_state_t  state;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] byte_dat;
    logic       tmo;

    rx_byte_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .clr          (state == IDLE),
        .shift_enable (shift_enable),
        .d_orig       (d_orig),
        .bit_cnt      (bit_cnt),
        .byte_done    (byte_done),
        .byte_dat     (byte_dat)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] cyc_cnt;
    rx_state_t     state_q;

    assign tmo = (cyc_cnt == TW'(TIMEOUT_CYC - 1)) && !shift_enable;

    // Counter restarts on every strobe and on the first cycle of each state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt <= '0;
            state_q <= IDLE;
        end else begin
            state_q <= state;
            if (state == IDLE || state == ERR || shift_enable || state != state_q)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            PID_I         <= 8'h00;
            rcv_data      <= 8'h00;
            byte_cnt      <= '0;
            EOP_flag      <= 1'b0;
            byte_received <= 1'b0;
            rcving        <= 1'b0;
            pid_err       <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            EOP_flag      <= 1'b0;
            byte_received <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SYNC_RX;
                        rcving   <= 1'b1;
                        byte_cnt <= '0;
                        pid_err  <= 1'b0;
                        rx_error <= 1'b0;
                    end
                end
                SYNC_RX: begin
                    if (eop || (byte_done && byte_dat != SYNC_BYTE)) begin
                        state    <= ERR;
                        rx_error <= 1'b1;
                    end else if (byte_done) begin
                        state <= PID_RX;
                    end else if (tmo) begin
                        state    <= IDLE;
                        rcving   <= 1'b0;
                        rx_error <= 1'b1;
                    end
                end
                PID_RX: begin
                    if (byte_done) begin
                        PID_I <= byte_dat;
                        if (!pid_ok(byte_dat)) begin
                            state    <= ERR;
                            pid_err  <= 1'b1;
                            rx_error <= 1'b1;
                        end else if (eop) begin
                            // Byte first, then eop lands on a boundary: zero-data packet.
                            state    <= IDLE;
                            rcving   <= 1'b0;
                            EOP_flag <= 1'b1;
                        end else begin
                            state <= DATA_RX;
                        end
                    end else if (eop) begin
                        state    <= ERR;
                        rx_error <= 1'b1;
                    end else if (tmo) begin
                        state    <= IDLE;
                        rcving   <= 1'b0;
                        rx_error <= 1'b1;
                    end
                end
                DATA_RX: begin
                    if (byte_done && byte_cnt == MAX_CNT) begin
                        state    <= ERR;
                        rx_error <= 1'b1;
                    end else begin
                        if (byte_done) begin
                            rcv_data      <= byte_dat;
                            byte_received <= 1'b1;
                            byte_cnt      <= byte_cnt + 1'b1;
                        end
                        if (eop) begin
                            if (byte_done || bit_cnt == 3'd0) begin
                                state    <= IDLE;
                                rcving   <= 1'b0;
                                EOP_flag <= 1'b1;
                            end else begin
                                state    <= ERR;
                                rx_error <= 1'b1;
                            end
                        end else if (tmo) begin
                            state    <= IDLE;
                            rcving   <= 1'b0;
                            rx_error <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (eop) begin
                        state  <= IDLE;
                        rcving <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rcving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_pid_framer.sv
// Directed bench for usb_rx_pid_framer (instance built with MAX_BYTES=4).
// Inputs change 1 ns after posedge; outputs are read at the same point.
module tb_usb_rx_pid_framer;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       d_orig = 1'b0;
    logic       shift_enable = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] PID_I;
    logic       EOP_flag;
    logic [7:0] rcv_data;
    logic       byte_received;
    logic [2:0] byte_cnt;
    logic       rcving;
    logic       pid_err;
    logic       rx_error;

    int n_vec = 0;
    int n_err = 0;
    int eop_seen = 0;
    int br_seen = 0;

    usb_rx_pid_framer #(.MAX_BYTES(4), .TIMEOUT_CYC(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .d_orig        (d_orig),
        .shift_enable  (shift_enable),
        .eop           (eop),
        .PID_I         (PID_I),
        .EOP_flag      (EOP_flag),
        .rcv_data      (rcv_data),
        .byte_received (byte_received),
        .byte_cnt      (byte_cnt),
        .rcving        (rcving),
        .pid_err       (pid_err),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (EOP_flag) eop_seen++;
        if (byte_received) br_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; shift_enable = 1'b0; eop = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        d_orig = b; shift_enable = 1'b1; tick();
        shift_enable = 1'b0; tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic pulse_eop();
        eop = 1'b1; tick(); eop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (PID_I !== 8'h00) begin n_err++; $display("FAIL reset_pid got %h exp 00", PID_I); end
        n_vec++; if (rcv_data !== 8'h00) begin n_err++; $display("FAIL reset_rcv_data got %h exp 00", rcv_data); end
        n_vec++; if ({EOP_flag, byte_received, byte_cnt, rcving, pid_err, rx_error} !== 8'h00) begin n_err++;
            $display("FAIL reset_flags got %b exp 00000000", {EOP_flag, byte_received, byte_cnt, rcving, pid_err, rx_error}); end
    endtask

    task automatic test_out_token();
        eop_seen = 0; br_seen = 0;
        pulse_start();
        n_vec++; if (rcving !== 1'b1) begin n_err++; $display("FAIL out_rcving got %b exp 1", rcving); end
        send_byte(8'h80);
        send_byte(8'hE1);
        n_vec++; if (PID_I !== 8'hE1) begin n_err++; $display("FAIL out_pid_early got %h exp e1", PID_I); end
        send_byte(8'h00);
        pulse_start(); // ignored outside IDLE
        n_vec++; if (byte_cnt !== 3'd1) begin n_err++; $display("FAIL out_start_ignored byte_cnt got %0d exp 1", byte_cnt); end
        send_byte(8'h10);
        pulse_eop();
        n_vec++; if (EOP_flag !== 1'b1) begin n_err++; $display("FAIL out_eop_flag got %b exp 1", EOP_flag); end
        tick();
        n_vec++; if (EOP_flag !== 1'b0) begin n_err++; $display("FAIL out_eop_width got %b exp 0", EOP_flag); end
        n_vec++; if (eop_seen !== 1) begin n_err++; $display("FAIL out_eop_count got %0d exp 1", eop_seen); end
        n_vec++; if (br_seen !== 2) begin n_err++; $display("FAIL out_byte_rcvd got %0d exp 2", br_seen); end
        n_vec++; if (byte_cnt !== 3'd2) begin n_err++; $display("FAIL out_byte_cnt got %0d exp 2", byte_cnt); end
        n_vec++; if (rcv_data !== 8'h10) begin n_err++; $display("FAIL out_rcv_data got %h exp 10", rcv_data); end
        n_vec++; if ({PID_I, rx_error, rcving} !== {8'hE1, 2'b00}) begin n_err++;
            $display("FAIL out_final pid/err/rcv got %h %b %b exp e1 0 0", PID_I, rx_error, rcving); end
    endtask

    task automatic test_ack();
        eop_seen = 0;
        pulse_start();
        send_byte(8'h80);
        send_byte(8'hD2);
        pulse_eop();
        n_vec++; if (EOP_flag !== 1'b1) begin n_err++; $display("FAIL ack_eop_flag got %b exp 1", EOP_flag); end
        n_vec++; if (PID_I !== 8'hD2) begin n_err++; $display("FAIL ack_pid got %h exp d2", PID_I); end
        n_vec++; if (byte_cnt !== 3'd0) begin n_err++; $display("FAIL ack_byte_cnt got %0d exp 0", byte_cnt); end
        tick();
        n_vec++; if (eop_seen !== 1) begin n_err++; $display("FAIL ack_eop_count got %0d exp 1", eop_seen); end
    endtask

    task automatic test_bad_pid();
        eop_seen = 0;
        pulse_start();
        send_byte(8'h80);
        send_byte(8'hE2);
        n_vec++; if ({pid_err, rx_error, rcving} !== 3'b111) begin n_err++;
            $display("FAIL badpid_flags got %b exp 111", {pid_err, rx_error, rcving}); end
        n_vec++; if (PID_I !== 8'hE2) begin n_err++; $display("FAIL badpid_pid got %h exp e2", PID_I); end
        pulse_eop();
        tick();
        n_vec++; if (rcving !== 1'b0) begin n_err++; $display("FAIL badpid_idle rcving got %b exp 0", rcving); end
        n_vec++; if ({pid_err, rx_error} !== 2'b11) begin n_err++; $display("FAIL badpid_sticky got %b exp 11", {pid_err, rx_error}); end
        n_vec++; if (eop_seen !== 0) begin n_err++; $display("FAIL badpid_no_eop got %0d exp 0", eop_seen); end
    endtask

    task automatic test_partial();
        eop_seen = 0;
        pulse_start();
        n_vec++; if ({pid_err, rx_error} !== 2'b00) begin n_err++; $display("FAIL partial_start_clear got %b exp 00", {pid_err, rx_error}); end
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'hA5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        pulse_eop();
        n_vec++; if ({rx_error, rcving, EOP_flag} !== 3'b110) begin n_err++;
            $display("FAIL partial_err got %b exp 110", {rx_error, rcving, EOP_flag}); end
        n_vec++; if (rcv_data !== 8'hA5) begin n_err++; $display("FAIL partial_rcv_data got %h exp a5", rcv_data); end
        pulse_eop();
        tick();
        n_vec++; if ({rx_error, rcving} !== 2'b10) begin n_err++; $display("FAIL partial_idle got %b exp 10", {rx_error, rcving}); end
        n_vec++; if (eop_seen !== 0) begin n_err++; $display("FAIL partial_no_eop got %0d exp 0", eop_seen); end
        pulse_start();
        n_vec++; if (rx_error !== 1'b0) begin n_err++; $display("FAIL partial_restart got %b exp 0", rx_error); end
        do_reset();
    endtask

    task automatic test_sync_reset();
        pulse_start();
        send_byte(8'h81);
        n_vec++; if ({rx_error, rcving} !== 2'b11) begin n_err++; $display("FAIL sync_mismatch got %b exp 11", {rx_error, rcving}); end
        rst = 1'b0; tick(); rst = 1'b1;
        n_vec++; if ({PID_I, rcv_data} !== 16'h0000) begin n_err++; $display("FAIL midreset_data got %h exp 0000", {PID_I, rcv_data}); end
        n_vec++; if ({EOP_flag, byte_received, byte_cnt, rcving, pid_err, rx_error} !== 8'h00) begin n_err++;
            $display("FAIL midreset_flags got %b exp 00000000", {EOP_flag, byte_received, byte_cnt, rcving, pid_err, rx_error}); end
    endtask

    task automatic test_overflow();
        br_seen = 0; eop_seen = 0;
        pulse_start();
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        n_vec++; if ({byte_cnt, rx_error} !== {3'd4, 1'b0}) begin n_err++;
            $display("FAIL ovf_four got cnt %0d err %b exp 4 0", byte_cnt, rx_error); end
        send_byte(8'h05);
        n_vec++; if ({rx_error, rcving} !== 2'b11) begin n_err++; $display("FAIL ovf_fifth got %b exp 11", {rx_error, rcving}); end
        n_vec++; if (br_seen !== 4) begin n_err++; $display("FAIL ovf_byte_rcvd got %0d exp 4", br_seen); end
        n_vec++; if (rcv_data !== 8'h04) begin n_err++; $display("FAIL ovf_rcv_data got %h exp 04", rcv_data); end
        pulse_eop();
        tick();
        n_vec++; if ({rcving, eop_seen != 0} !== 2'b00) begin n_err++;
            $display("FAIL ovf_exit got rcving %b eop %0d exp 0 0", rcving, eop_seen); end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'h80);
        for (int i = 0; i < 70; i++) tick();
`ifdef RX_TIMEOUT_EN
        n_vec++; if ({rx_error, rcving} !== 2'b10) begin n_err++; $display("FAIL timeout_fire got %b exp 10", {rx_error, rcving}); end
`else
        n_vec++; if ({rx_error, rcving} !== 2'b01) begin n_err++; $display("FAIL timeout_wait got %b exp 01", {rx_error, rcving}); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_out_token();
        test_ack();
        test_bad_pid();
        test_partial();
        test_sync_reset();
        test_overflow();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
